// File: rtl/wave_channel_sequencer.sv
// Wave channel (APU channel 3) playback: frequency timer, 32-step sample position,
// wave RAM byte fetch, nibble select, trigger/DAC gating and the 256-step length counter.
module wave_channel_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_en,
    input  logic        dac_on,
    input  logic [10:0] freq,
    input  logic        trigger,
    input  logic        length_write,
    input  logic [7:0]  length_load,
    input  logic        length_enable,
    input  logic        frame_len_tick,
    output logic [3:0]  wave_ram_addr,
    input  logic [7:0]  wave_ram_data,
    output logic [3:0]  wave_raw,
    output logic        sample_strobe,
    output logic        active
);

    logic [10:0] timer, timer_d;
    logic [4:0]  pos, pos_d;
    logic [7:0]  sample_buf, sample_buf_d;
    logic [8:0]  length_ctr, length_ctr_d;
    logic        fetch_pend, fetch_pend_d;
    logic        active_d;
    logic        strobe_d;
    logic [10:0] reload;
    logic        run;
    logic        len_step;

    assign reload   = 11'h7FF - freq;
    // Timer and position freeze as soon as the DAC is off, not one tick later.
    assign run      = active & dac_on;
    assign len_step = frame_len_tick & length_enable & (length_ctr != 9'd0);

    always_comb begin
        timer_d      = timer;
        pos_d        = pos;
        sample_buf_d = sample_buf;
        length_ctr_d = length_ctr;
        fetch_pend_d = fetch_pend;
        active_d     = active;
        strobe_d     = 1'b0;
        if (cpu_en) begin
            if (trigger) begin
                // Trigger wins over advance, fetch and the length tick in the same edge.
                pos_d        = 5'd0;
                timer_d      = reload;
                fetch_pend_d = 1'b0;
                active_d     = 1'b1;
                if (length_write)
                    length_ctr_d = 9'd256 - {1'b0, length_load};
                else if (length_ctr == 9'd0)
                    length_ctr_d = 9'd256;
            end else begin
                if (fetch_pend) begin
                    sample_buf_d = wave_ram_data;
                    fetch_pend_d = 1'b0;
                    strobe_d     = 1'b1;
                end
                if (run) begin
                    if (timer == 11'd0) begin
                        timer_d      = reload;
                        pos_d        = pos + 5'd1;
                        fetch_pend_d = 1'b1;
                    end else begin
                        timer_d = timer - 11'd1;
                    end
                end
                if (length_write) begin
                    length_ctr_d = 9'd256 - {1'b0, length_load};
                end else if (len_step) begin
                    length_ctr_d = length_ctr - 9'd1;
                    if (length_ctr == 9'd1)
                        active_d = 1'b0;
                end
            end
            if (!dac_on)
                active_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer         <= 11'd0;
            pos           <= 5'd0;
            sample_buf    <= 8'd0;
            length_ctr    <= 9'd0;
            fetch_pend    <= 1'b0;
            active        <= 1'b0;
            sample_strobe <= 1'b0;
        end else begin
            timer         <= timer_d;
            pos           <= pos_d;
            sample_buf    <= sample_buf_d;
            length_ctr    <= length_ctr_d;
            fetch_pend    <= fetch_pend_d;
            active        <= active_d;
            sample_strobe <= strobe_d;
        end
    end

    assign wave_ram_addr = pos[4:1];
    assign wave_raw      = !active ? 4'h0 : (pos[0] ? sample_buf[3:0] : sample_buf[7:4]);

endmodule

// File: tb/tb_wave_channel_sequencer.sv
// Directed bench for wave_channel_sequencer: a vector table for basic playback and
// DAC gating, then hand-written sequences for period, wrap, length, collision and reset.
module tb_wave_channel_sequencer;

    logic        clk;
    logic        reset;
    logic        cpu_en;
    logic        dac_on;
    logic [10:0] freq;
    logic        trigger;
    logic        length_write;
    logic [7:0]  length_load;
    logic        length_enable;
    logic        frame_len_tick;
    logic [3:0]  wave_ram_addr;
    logic [7:0]  wave_ram_data;
    logic [3:0]  wave_raw;
    logic        sample_strobe;
    logic        active;

    logic [7:0]  ram [16];
    int          checks;
    int          errors;

    typedef struct {
        logic       en;
        logic       dac;
        logic       trig;
        logic [3:0] addr;
        logic [3:0] raw;
        logic       strobe;
        logic       act;
    } vec_t;

    vec_t vecs [13];

    wave_channel_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_en         (cpu_en),
        .dac_on         (dac_on),
        .freq           (freq),
        .trigger        (trigger),
        .length_write   (length_write),
        .length_load    (length_load),
        .length_enable  (length_enable),
        .frame_len_tick (frame_len_tick),
        .wave_ram_addr  (wave_ram_addr),
        .wave_ram_data  (wave_ram_data),
        .wave_raw       (wave_raw),
        .sample_strobe  (sample_strobe),
        .active         (active)
    );

    assign wave_ram_data = ram[wave_ram_addr];

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act_v, input logic [15:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s actual %0h expected %0h", name, act_v, exp_v);
        end
    endtask

    task automatic cyc(input logic e, input logic t, input logic w, input logic f);
        cpu_en         = e;
        trigger        = t;
        length_write   = w;
        frame_len_tick = f;
        @(posedge clk);
        #1;
        cpu_en         = 1'b0;
        trigger        = 1'b0;
        length_write   = 1'b0;
        frame_len_tick = 1'b0;
    endtask

    task automatic do_reset();
        reset          = 1'b0;
        cpu_en         = 1'b0;
        dac_on         = 1'b0;
        freq           = 11'd0;
        trigger        = 1'b0;
        length_write   = 1'b0;
        length_load    = 8'd0;
        length_enable  = 1'b0;
        frame_len_tick = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        int first;
        int drop;
        checks = 0;
        errors = 0;
        for (int i = 0; i < 16; i++)
            ram[i] = {4'(i), 4'(i) ^ 4'h5};
        ram[0] = 8'hAB;
        ram[1] = 8'hCD;

        //             en    dac   trig  addr  raw   stb   act
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 4'h0, 4'hB, 1'b1, 1'b1};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 4'h1, 4'hA, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 4'h1, 4'hC, 1'b1, 1'b1};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 4'h1, 4'hD, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 4'h1, 4'hD, 1'b1, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 4'h1, 4'hD, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 4'h1, 4'h0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 4'h1, 4'h0, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0};

        // reset state
        do_reset();
        chk("reset_addr", 16'(wave_ram_addr), 16'h0);
        chk("reset_raw", 16'(wave_raw), 16'h0);
        chk("reset_strobe", 16'(sample_strobe), 16'h0);
        chk("reset_active", 16'(active), 16'h0);

        // basic playback at freq 2046 and DAC gating
        freq = 11'd2046;
        for (int i = 0; i < 13; i++) begin
            dac_on = vecs[i].dac;
            cyc(vecs[i].en, vecs[i].trig, 1'b0, 1'b0);
            chk($sformatf("vec%0d_addr", i), 16'(wave_ram_addr), 16'(vecs[i].addr));
            chk($sformatf("vec%0d_raw", i), 16'(wave_raw), 16'(vecs[i].raw));
            chk($sformatf("vec%0d_strobe", i), 16'(sample_strobe), 16'(vecs[i].strobe));
            chk($sformatf("vec%0d_active", i), 16'(active), 16'(vecs[i].act));
        end

        // period at freq 0: first fetch strobe one tick after the 2048th tick
        do_reset();
        dac_on = 1'b1;
        freq   = 11'd0;
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        first = 0;
        for (int e = 1; e <= 2100; e++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            if (sample_strobe && first == 0) begin
                first = e;
                break;
            end
        end
        chk("period_strobe_tick", 16'(first), 16'd2049);
        chk("period_raw", 16'(wave_raw), 16'hB);

        // wrap from pos 31 to 0
        do_reset();
        dac_on = 1'b1;
        freq   = 11'd2046;
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        for (int e = 1; e <= 65; e++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            if (e == 62) chk("wrap_addr31", 16'(wave_ram_addr), 16'hF);
            if (e == 63) chk("wrap_raw31", 16'(wave_raw), 16'(ram[15][3:0]));
            if (e == 64) chk("wrap_addr0", 16'(wave_ram_addr), 16'h0);
            if (e == 65) begin
                chk("wrap_raw0", 16'(wave_raw), 16'(ram[0][7:4]));
                chk("wrap_strobe", 16'(sample_strobe), 16'h1);
            end
        end

        // length counter: load 0xFE gives two steps
        do_reset();
        dac_on        = 1'b1;
        freq          = 11'd2046;
        length_load   = 8'hFE;
        length_enable = 1'b1;
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        chk("len_first_tick_active", 16'(active), 16'h1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        chk("len_second_tick_active", 16'(active), 16'h0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 0);
        chk("len_expired_raw", 16'(wave_raw), 16'h0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("len_retrigger_active", 16'(active), 16'h1);
        drop = 0;
        for (int t = 1; t <= 300; t++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b1);
            if (!active) begin
                drop = t;
                break;
            end
        end
        chk("len_reload_256", 16'(drop), 16'd256);

        // trigger with frame_len_tick in the same edge: the tick is ignored
        do_reset();
        dac_on        = 1'b1;
        freq          = 11'd2046;
        length_load   = 8'hFE;
        length_enable = 1'b1;
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        chk("collide_after_one_tick", 16'(active), 16'h1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        chk("collide_after_two_ticks", 16'(active), 16'h0);

        // reset between an advance and its fetch
        do_reset();
        dac_on = 1'b1;
        freq   = 11'd2046;
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        for (int e = 1; e <= 4; e++)
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("midreset_pre_addr", 16'(wave_ram_addr), 16'h1);
        reset = 1'b0;
        #2;
        chk("midreset_async_active", 16'(active), 16'h0);
        chk("midreset_async_addr", 16'(wave_ram_addr), 16'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        first = 0;
        for (int e = 1; e <= 3; e++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            if (sample_strobe) first++;
        end
        chk("midreset_no_strobe", 16'(first), 16'd0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("midreset_trig_active", 16'(active), 16'h1);
        chk("midreset_buf_cleared", 16'(wave_raw), 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
